fb_dump_reader: RTL
===================

// Module: fb_dump_reader
// PURPOSE
//  Bus initiator that reads a memory window (default frame buffer 0xc000-0xffff) over the
//  16-bit data-port protocol and streams it out as bytes on a valid/ready interface.
//  It sits beside risc16b on the data-memory bus behind a req/gnt arbiter, and is the
//  reader for the image the CPU writes. Byte order follows the bus: even address = din[15:8].
// PARAMETERS
//  BASE_ADDR  16'hc000  first byte address read; must be even
//  LAST_ADDR  16'hffff  last byte address read, inclusive; must be odd and > BASE_ADDR
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous, active-high reset
//  start      in   1   begin a dump; sampled only in IDLE
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle pulse after the last byte is accepted
//  m_req      out  1   bus request to arbiter
//  m_gnt      in   1   bus grant; the block drives m_oe only while m_gnt=1
//  m_addr     out  16  word address (bit0 always 0)
//  m_oe       out  1   read enable; m_din is valid combinationally in the same cycle
//  m_din      in   16  read data {byte[addr], byte[addr|1]}
//  out_data   out  8   stream byte
//  out_valid  out  1   out_data valid
//  out_ready  in   1   consumer accepts when out_valid & out_ready at posedge
//  out_last   out  1   marks the byte at LAST_ADDR
// BEHAVIOUR
//  Reset: state IDLE; addr reg=BASE_ADDR; word buffer=0. busy, done, m_req, m_oe,
//   out_valid and out_last are 0; m_addr=BASE_ADDR; out_data=0. Reset mid-dump aborts
//   with no flush, and the next dump restarts at BASE_ADDR.
//  FSM states: IDLE, REQ, READ, HI, LO, DONE.
//   IDLE: if start=1, load addr=BASE_ADDR and go to REQ. start in any other state is ignored.
//   REQ : m_req=1 and m_oe=0. If m_gnt=1, go to READ; otherwise stay in REQ.
//   READ: m_req=1 and m_oe=m_gnt. If m_gnt=1, capture m_din into the word buffer and go
//         to HI. If m_gnt=0, go back to REQ; no capture and no address change.
//   HI  : m_req=0, out_valid=1, out_data=buf[15:8], out_last=0. On accept, go to LO.
//   LO  : out_valid=1, out_data=buf[7:0], out_last=(addr==LAST_ADDR-1).
//         On accept: if last, go to DONE; else addr+=2 and go to REQ.
//   DONE: done=1 for one cycle, then IDLE.
//  Stream rules: out_data and out_last are held stable while out_valid=1 & out_ready=0.
//   out_valid never drops without an accept.
//  m_addr=addr reg, held constant across REQ/READ retries.
//  Termination is by compare only. addr is 16-bit and may not wrap past 0xfffe.
//   With LAST_ADDR=0xffff, addr never advances to 0x0000, and m_oe is never
//   asserted for an address outside [BASE_ADDR, LAST_ADDR].
//  Latency: start sampled at edge E0 -> REQ. With m_gnt=1 -> READ after E1 -> first
//   out_valid after E2. Minimum 4 cycles per word with gnt=ready=1.
//   Total bytes = LAST_ADDR-BASE_ADDR+1 (16384 at defaults).
//  The bus is released (m_req=0) while bytes drain, so the CPU can run between words.
// TESTING
//  1 Assert rst for 2 cycles mid-run -> next cycle: all outputs 0, m_addr=BASE, busy=0.
//  2 BASE=c000, LAST=c003, mem c000..c003=12 34 56 78, gnt=ready=1; pulse start ->
//    bytes 12,34,56,78; out_last only on 78; done one cycle later; first valid at E2.
//  3 Same setup, ready=0 for 5 cycles while showing 0x34 -> out_data stays 34,
//    m_req=0, m_addr stays c000; on ready=1, stream continues 56,78 with no loss.
//  4 Hold gnt=0 for 3 cycles in REQ, then drop gnt for 1 cycle in READ -> m_oe=0 in
//    those cycles; the word at c002 is read exactly once; stream is 12 34 56 78.
//  5 Defaults, mem[i]=i[7:0]^i[15:8], gnt=ready=1 -> 16384 bytes match; last byte
//    from ffff; m_oe never seen with m_addr=0000; start pulses while busy ignored.
//  6 rst during the LO of word c002, then start -> fresh dump from c000, byte 12 first.

Source files
------------

// File: rtl/fb_dump_reader.sv
// Bus initiator that reads a byte window over the 16-bit data-port bus and
// streams it out one byte at a time (even address first) on a valid/ready port.
module fb_dump_reader #(
  parameter logic [15:0] BASE_ADDR = 16'hc000,
  parameter logic [15:0] LAST_ADDR = 16'hffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        m_req,
  input  logic        m_gnt,
  output logic [15:0] m_addr,
  output logic        m_oe,
  input  logic [15:0] m_din,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_READ = 3'd2,
    S_HI   = 3'd3,
    S_LO   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Word address holding the final byte; termination is by compare, so the
  // address register never steps past it and cannot wrap.
  localparam logic [15:0] LAST_WORD = LAST_ADDR - 16'd1;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] buf_q, buf_d;
  logic        last_word;

  assign last_word = (addr_q == LAST_WORD);
  assign m_addr    = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      buf_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    busy      = 1'b1;
    done      = 1'b0;
    m_req     = 1'b0;
    m_oe      = 1'b0;
    out_data  = 8'h00;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          addr_d  = BASE_ADDR;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        m_req = 1'b1;
        if (m_gnt) begin
          state_d = S_READ;
        end else begin
          state_d = S_REQ;
        end
      end
      S_READ: begin
        // m_oe follows the grant so the bus is never driven without it.
        m_req = 1'b1;
        m_oe  = m_gnt;
        if (m_gnt) begin
          buf_d   = m_din;
          state_d = S_HI;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HI: begin
        out_valid = 1'b1;
        out_data  = buf_q[15:8];
        if (out_ready) begin
          state_d = S_LO;
        end else begin
          state_d = S_HI;
        end
      end
      S_LO: begin
        out_valid = 1'b1;
        out_data  = buf_q[7:0];
        out_last  = last_word;
        if (out_ready) begin
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 16'd2;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_LO;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
